// File: rtl/adam_aes_seq.sv
// Drives one AES job at a time through the register bus of an AES core: config, key, init, block, next, result.
// Optional key cache (skips key load and init for a repeated key): define ADAM_AES_SEQ_KEY_CACHE_EN.
module adam_aes_seq #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [255:0] req_key,
    input  logic         req_keylen,
    input  logic         req_encdec,
    input  logic [127:0] req_block,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_data,
    output logic         rsp_err,
    output logic         busy,
    output logic         aes_cs,
    output logic         aes_we,
    output logic [7:0]   aes_address,
    output logic [31:0]  aes_write_data,
    input  logic [31:0]  aes_read_data
);
    typedef enum logic [3:0] {
        IDLE, WCFG, WKEY, INIT, WAIT_RDY, WBLK, NEXT, WAIT_VLD, RRES, DONE
    } state_t;

    localparam logic [15:0] POLL_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t        state, state_next;
    logic [15:0]   count, count_next;
    logic [255:0]  job_key;
    logic          job_keylen;
    logic [127:0]  job_block;
    logic          accept, timeout, cache_hit;
    logic          cs_next, we_next;
    logic [7:0]    addr_next;
    logic [31:0]   wdata_next;

    function automatic logic [31:0] key_word(input logic [255:0] key, input logic [2:0] idx);
        logic [255:0] shifted;
        shifted = key << {idx, 5'd0};
        return shifted[255:224];
    endfunction

    function automatic logic [31:0] block_word(input logic [127:0] blk, input logic [1:0] idx);
        logic [127:0] shifted;
        shifted = blk << {idx, 5'd0};
        return shifted[127:96];
    endfunction

    assign accept = req_valid && req_ready;

    always_comb begin
        state_next = state;
        count_next = count;
        timeout    = 1'b0;
        case (state)
            IDLE:     if (accept) state_next = WCFG;
            WCFG:     state_next = cache_hit ? WBLK : WKEY;
            WKEY:     if (count[2:0] == {job_keylen, 2'b11}) state_next = INIT;
            INIT:     state_next = WAIT_RDY;
            // count 0 is the guard read right after the CTRL write; its STATUS may be stale
            WAIT_RDY: begin
                if (count != '0 && aes_read_data[0]) state_next = WBLK;
                else if (count == POLL_LAST) begin
                    state_next = DONE;
                    timeout    = 1'b1;
                end
            end
            WBLK:     if (count[1:0] == 2'd3) state_next = NEXT;
            NEXT:     state_next = WAIT_VLD;
            WAIT_VLD: begin
                if (count != '0 && aes_read_data[1]) state_next = RRES;
                else if (count == POLL_LAST) begin
                    state_next = DONE;
                    timeout    = 1'b1;
                end
            end
            RRES:     if (count[1:0] == 2'd3) state_next = DONE;
            DONE:     if (rsp_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase

        if (state_next != state) count_next = '0;
        else if (state != IDLE && state != DONE) count_next = count + 16'd1;

        // Bus outputs are registered, so decode the access of the cycle being entered
        cs_next    = 1'b1;
        we_next    = 1'b0;
        addr_next  = '0;
        wdata_next = '0;
        case (state_next)
            WCFG: begin
                we_next    = 1'b1;
                addr_next  = 8'h28;
                wdata_next = {30'd0, req_keylen, req_encdec};
            end
            WKEY: begin
                we_next    = 1'b1;
                addr_next  = {3'b010, count_next[2:0], 2'b00};
                wdata_next = key_word(job_key, count_next[2:0]);
            end
            INIT: begin
                we_next    = 1'b1;
                addr_next  = 8'h20;
                wdata_next = 32'h1;
            end
            WAIT_RDY, WAIT_VLD: addr_next = 8'h24;
            WBLK: begin
                we_next    = 1'b1;
                addr_next  = {4'h8, count_next[1:0], 2'b00};
                wdata_next = block_word(job_block, count_next[1:0]);
            end
            NEXT: begin
                we_next    = 1'b1;
                addr_next  = 8'h20;
                wdata_next = 32'h2;
            end
            RRES:    addr_next = {4'hC, count_next[1:0], 2'b00};
            default: cs_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            count          <= '0;
            req_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_err        <= 1'b0;
            rsp_data       <= '0;
            busy           <= 1'b0;
            aes_cs         <= 1'b0;
            aes_we         <= 1'b0;
            aes_address    <= '0;
            aes_write_data <= '0;
        end else begin
            state          <= state_next;
            count          <= count_next;
            req_ready      <= (state_next == IDLE);
            busy           <= (state_next != IDLE);
            rsp_valid      <= (state_next == DONE);
            aes_cs         <= cs_next;
            aes_we         <= we_next;
            aes_address    <= addr_next;
            aes_write_data <= wdata_next;
            if (timeout) begin
                rsp_err  <= 1'b1;
                rsp_data <= '0;
            end else if (state_next != DONE) begin
                rsp_err  <= 1'b0;
            end
            if (state == RRES) begin
                case (count[1:0])
                    2'd0:    rsp_data[127:96] <= aes_read_data;
                    2'd1:    rsp_data[95:64]  <= aes_read_data;
                    2'd2:    rsp_data[63:32]  <= aes_read_data;
                    default: rsp_data[31:0]   <= aes_read_data;
                endcase
            end
        end
    end

    logic job_encdec_unused;
    always_ff @(posedge clk) begin
        if (accept) begin
            job_key           <= req_key;
            job_keylen        <= req_keylen;
            job_encdec_unused <= req_encdec;
            job_block         <= req_block;
        end
    end

`ifdef ADAM_AES_SEQ_KEY_CACHE_EN
    logic         cache_valid;
    logic [255:0] cache_key;
    logic         cache_keylen;
    logic         key_loaded;

    assign key_loaded = (state == WAIT_RDY) && (state_next == WBLK);
    assign cache_hit  = cache_valid && (cache_key == job_key) && (cache_keylen == job_keylen);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cache_valid <= 1'b0;
        else if (timeout) cache_valid <= 1'b0;
        else if (key_loaded) cache_valid <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (key_loaded) begin
            cache_key    <= job_key;
            cache_keylen <= job_keylen;
        end
    end
`else
    assign cache_hit = 1'b0;
`endif
endmodule

// File: tb/tb_adam_aes_seq.sv
// Randomized jobs against a register-level AES core model; expectations come from a job-level reference.
module tb_adam_aes_seq;
    localparam int TO = 8;
`ifdef ADAM_AES_SEQ_KEY_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    localparam logic [127:0] K128  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [255:0] req_key = '0;
    logic         req_keylen = 1'b0;
    logic         req_encdec = 1'b0;
    logic [127:0] req_block = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [127:0] rsp_data;
    logic         rsp_err;
    logic         busy;
    logic         aes_cs, aes_we;
    logic [7:0]   aes_address;
    logic [31:0]  aes_write_data;
    logic [31:0]  aes_read_data;

    always #5 clk = ~clk;

    adam_aes_seq #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_keylen(req_keylen), .req_encdec(req_encdec), .req_block(req_block),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy),
        .aes_cs(aes_cs), .aes_we(aes_we), .aes_address(aes_address),
        .aes_write_data(aes_write_data), .aes_read_data(aes_read_data)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Core cipher: known answers for the published vectors, a keyed mixing function otherwise
    function automatic logic [127:0] core_fn(input logic [255:0] k, input logic kl, input logic ed,
                                             input logic [127:0] b);
        logic [127:0] ke;
        if (!kl && ed && k[255:128] == K128 && b == PT) return CT128;
        if (kl && ed && k == K256 && b == PT) return CT256;
        if (!kl && !ed && k[255:128] == K128 && b == CT128) return PT;
        ke = kl ? (k[255:128] ^ {k[63:0], k[127:64]}) : k[255:128];
        return {b[94:0], b[127:95]} ^ ke ^
               (ed ? 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0 : 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f);
    endfunction

    // AES core register model; STATUS shows stale 1s in the cycle right after a CTRL write
    int           d_rdy = 0, d_vld = 0;
    logic         stuck = 1'b0;
    logic [255:0] c_key = '0;
    logic [127:0] c_blk = '0, c_res = '0;
    logic [1:0]   c_cfg = '0;
    int           rdy_t = 0, vld_t = 0;
    logic         stale = 1'b0;

    always @(posedge clk) begin
        stale <= 1'b0;
        if (rdy_t > 0) rdy_t <= rdy_t - 1;
        if (vld_t > 0) vld_t <= vld_t - 1;
        if (aes_cs && aes_we) begin
            if (aes_address == 8'h28) c_cfg <= aes_write_data[1:0];
            else if (aes_address == 8'h20) begin
                stale <= 1'b1;
                if (aes_write_data[0]) rdy_t <= d_rdy + 1;
                if (aes_write_data[1]) begin
                    vld_t <= d_vld + 1;
                    c_res <= core_fn(c_key, c_cfg[1], c_cfg[0], c_blk);
                end
            end else if (aes_address[7:5] == 3'b010)
                c_key[(7 - int'(aes_address[4:2])) * 32 +: 32] <= aes_write_data;
            else if (aes_address[7:4] == 4'h8)
                c_blk[(3 - int'(aes_address[3:2])) * 32 +: 32] <= aes_write_data;
        end
    end

    always_comb begin
        aes_read_data = 32'h0;
        if (aes_cs && !aes_we) begin
            if (aes_address == 8'h24)
                aes_read_data = stuck ? 32'h0 : {30'd0, stale | (vld_t == 0), stale | (rdy_t == 0)};
            else if (aes_address[7:4] == 4'hC)
                aes_read_data = c_res[(3 - int'(aes_address[3:2])) * 32 +: 32];
        end
    end

    // Bus monitor: running totals, compared per job as deltas
    int          m_acc = 0, m_key = 0, m_init = 0, m_next = 0, m_idle = 0;
    logic [31:0] m_cfg = '0;

    always @(negedge clk) begin
        if (aes_cs) m_acc <= m_acc + 1;
        else if (aes_we || aes_address != 8'h0 || aes_write_data != 32'h0) m_idle <= m_idle + 1;
        if (aes_cs && aes_we) begin
            if (aes_address[7:5] == 3'b010) m_key <= m_key + 1;
            if (aes_address == 8'h20 && aes_write_data == 32'h1) m_init <= m_init + 1;
            if (aes_address == 8'h20 && aes_write_data == 32'h2) m_next <= m_next + 1;
            if (aes_address == 8'h28) m_cfg <= aes_write_data;
        end
    end

    logic         tc_valid = 1'b0;
    logic [255:0] tc_key = '0;
    logic         tc_kl = 1'b0;

    task automatic run_job(input logic [255:0] k, input logic kl, input logic ed, input logic [127:0] b,
                           input int dr, input int dv, input logic stk, input int hold);
        int nk, lat, cyc, bad, a0, k0, i0, n0, v0;
        logic skip, exp_err;
        logic [127:0] exp_data, held;
        nk   = kl ? 8 : 4;
        skip = CACHE_EN && tc_valid && tc_key == k && tc_kl == kl;
        if (stk) begin
            exp_err  = 1'b1;
            exp_data = '0;
            lat      = skip ? 1 + 4 + 1 + TO : 1 + nk + 1 + TO;
            tc_valid = 1'b0;
        end else begin
            exp_err  = 1'b0;
            exp_data = core_fn(k, kl, ed, b);
            lat      = 1 + (skip ? 0 : nk + 1 + dr + 2) + 4 + 1 + dv + 2 + 4;
            if (!skip) begin
                tc_valid = 1'b1;
                tc_key   = k;
                tc_kl    = kl;
            end
        end

        @(negedge clk);
        d_rdy = dr; d_vld = dv; stuck = stk;
        req_key = k; req_keylen = kl; req_encdec = ed; req_block = b; req_valid = 1'b1;
        rsp_ready = (hold == 0);
        a0 = m_acc; k0 = m_key; i0 = m_init; n0 = m_next; v0 = m_idle;
        check("req_ready_idle", 128'(req_ready), 128'(1));
        @(posedge clk);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                req_valid  = 1'($urandom_range(0, 1));
                req_key    = {8{$urandom}};
                req_block  = {4{$urandom}};
                req_keylen = ~kl;
                req_encdec = ~ed;
            end
        end while (!rsp_valid && cyc < 400);
        req_valid = 1'b0;

        check("rsp_valid_seen", 128'(rsp_valid), 128'(1));
        check("latency", 128'(cyc), 128'(lat + 1));
        check("rsp_data", rsp_data, exp_data);
        check("rsp_err", 128'(rsp_err), 128'(exp_err));
        check("busy_done", 128'(busy), 128'(1));

        held = rsp_data;
        bad  = 0;
        for (int h = 1; h <= hold; h++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_data !== held || rsp_err !== exp_err || req_ready) bad++;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("hold_stable", 128'(bad), 128'(0));
        check("rsp_valid_after", 128'(rsp_valid), 128'(0));
        check("req_ready_after", 128'(req_ready), 128'(1));

        check("access_count", 128'(m_acc - a0), 128'(lat));
        check("key_writes", 128'(m_key - k0), 128'(skip ? 0 : nk));
        check("init_writes", 128'(m_init - i0), 128'(skip ? 0 : 1));
        check("next_writes", 128'(m_next - n0), 128'((stk && !skip) ? 0 : 1));
        check("config_word", 128'(m_cfg), 128'({30'd0, kl, ed}));
        check("idle_bus_zero", 128'(m_idle - v0), 128'(0));
    endtask

    task automatic reset_mid_wblk(input logic [255:0] k);
        int cyc;
        logic seen;
        @(negedge clk);
        d_rdy = 0; d_vld = 0; stuck = 1'b0;
        req_key = k; req_keylen = 1'b0; req_encdec = 1'b1; req_block = PT; req_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!(aes_cs && aes_we && aes_address[7:4] == 4'h8) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("wblk_reached", 128'(aes_address[7:4]), 128'(4'h8));
        reset_n = 1'b0;
        #1;
        check("rst_req_ready", 128'(req_ready), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_aes_cs", 128'(aes_cs), 128'(0));
        check("rst_rsp_data", rsp_data, 128'(0));
        tc_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid || busy) seen = 1'b1;
        end
        rsp_ready = 1'b0;
        check("no_rsp_after_reset", 128'(seen), 128'(0));
    endtask

    initial begin
        logic [255:0] pool [3];
        logic [255:0] kk;
        for (int i = 0; i < 3; i++) pool[i] = {$urandom, $urandom, $urandom, $urandom,
                                               $urandom, $urandom, $urandom, $urandom};

        repeat (2) @(negedge clk);
        check("reset_req_ready", 128'(req_ready), 128'(0));
        check("reset_rsp_valid", 128'(rsp_valid), 128'(0));
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_aes_cs", 128'(aes_cs), 128'(0));
        check("reset_rsp_err", 128'(rsp_err), 128'(0));
        check("reset_rsp_data", rsp_data, 128'(0));
        reset_n = 1'b1;
        #1;
        check("req_ready_before_edge", 128'(req_ready), 128'(0));
        @(negedge clk);
        check("req_ready_first_cycle", 128'(req_ready), 128'(1));

        run_job({K128, 128'h0}, 1'b0, 1'b1, PT, 0, 0, 1'b0, 0);
        run_job(K256, 1'b1, 1'b1, PT, 1, 2, 1'b0, 0);
        run_job({K128, 128'hffffffff_00000000_ffffffff_00000000}, 1'b0, 1'b0, CT128, 0, 1, 1'b0, 5);
        run_job(pool[0], 1'b1, 1'b1, {4{$urandom}}, 0, 0, 1'b1, 2);
        run_job(pool[0], 1'b1, 1'b0, {4{$urandom}}, 2, 1, 1'b0, 1);

        kk = {8{$urandom}};
        run_job(kk, 1'b1, 1'b1, {4{$urandom}}, 3, 0, 1'b0, 0);
        run_job(kk, 1'b1, 1'b1, {4{$urandom}}, 3, 0, 1'b0, 0);

        for (int j = 0; j < 24; j++) begin
            run_job(pool[$urandom_range(0, 2)], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    {$urandom, $urandom, $urandom, $urandom},
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)));
        end

        run_job(pool[1], 1'b0, 1'b1, PT, 0, 0, 1'b0, 0);
        reset_mid_wblk(pool[1]);
        run_job(pool[1], 1'b0, 1'b1, PT, 0, 0, 1'b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/adam_aes_seq.md
ADAM_AES_SEQ -- requirements
Module: adam_aes_seq

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum number of STATUS poll cycles per wait phase before the job is aborted (valid range 2..65535).
REQ-002 SHALL have port clk, input, 1: single clock for all logic.
REQ-003 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 1: a job is presented.
REQ-005 SHALL have port req_ready, output, 1: the block accepts a job.
REQ-006 SHALL have the following job fields, all inputs: req_key (256, key; bits [255:224] go to KEY0), req_keylen (1; 0 = 128-bit key, 1 = 256-bit key), req_encdec (1; 1 = encrypt), req_block (128, input block; bits [127:96] go to BLOCK0).
REQ-007 SHALL have port rsp_valid, output, 1: a result is presented.
REQ-008 SHALL have port rsp_ready, input, 1: the consumer accepts the result.
REQ-009 SHALL have port rsp_data, output, 128: result; RESULT0 maps to bits [127:96].
REQ-010 SHALL have port rsp_err, output, 1: the job timed out.
REQ-011 SHALL have port busy, output, 1: the FSM is not in IDLE.
REQ-012 SHALL have the following core bus ports: aes_cs (output, 1), aes_we (output, 1), aes_address (output, 8, byte address), aes_write_data (output, 32), aes_read_data (input, 32, combinational from aes_address while aes_cs=1 and aes_we=0).

Function
REQ-013 SHALL use this register map: CONFIG 0x28 (bit0 encdec, bit1 keylen); CTRL 0x20 (bit0 init, bit1 next); STATUS 0x24 (bit0 ready, bit1 valid); KEY0-7 0x40-0x5C; BLOCK0-3 0x80-0x8C; RESULT0-3 0xC0-0xCC.
REQ-014 SHALL drive req_ready=1 only in IDLE, and SHALL capture all request fields on the req_valid && req_ready cycle.
REQ-015 SHALL sequence each job through the states IDLE, WCFG, WKEY, INIT, WAIT_RDY, WBLK, NEXT, WAIT_VLD, RRES, DONE.
REQ-016 SHALL perform exactly one core access per cycle in every state except IDLE and DONE.
REQ-017 SHALL drive aes_cs=0, aes_we=0, and address and data = 0 whenever no access is performed.
REQ-018 WCFG SHALL last 1 cycle: write CONFIG = {30'b0, keylen, encdec}.
REQ-019 WKEY SHALL write KEY0 upward, one word per cycle: 4 words if keylen=0, 8 words if keylen=1.
REQ-020 INIT SHALL write CTRL=0x1 for 1 cycle.
REQ-021 NEXT SHALL write CTRL=0x2 for 1 cycle.
REQ-022 WBLK SHALL write BLOCK0 through BLOCK3, one word per cycle.
REQ-023 WAIT_RDY and WAIT_VLD SHALL read STATUS every cycle; the first cycle after the CTRL write is a guard cycle and its sample is ignored.
REQ-024 WAIT_RDY SHALL exit when STATUS bit0=1; WAIT_VLD SHALL exit when STATUS bit1=1.
REQ-025 RRES SHALL read RESULT0 through RESULT3 over 4 cycles, each word registered into rsp_data in its read cycle.
REQ-026 Timeout: the poll counter SHALL reset on entry to each wait state; on reaching TIMEOUT_CYCLES the FSM SHALL go to DONE with rsp_err=1 and rsp_data=0.
REQ-027 DONE SHALL hold rsp_valid=1 with stable rsp_data and rsp_err until rsp_ready=1, then return to IDLE. rsp_ready=1 already in the DONE entry cycle completes the handshake in that cycle.
REQ-028 Minimum latency from the accept cycle to rsp_valid, 128-bit key with the core responding immediately: 1+4+1+2+4+1+2+4 = 19 cycles, so rsp_valid rises in cycle 20.
REQ-029 req_valid SHALL be ignored outside IDLE; no job is queued.

Reset
REQ-030 While reset_n=0, SHALL asynchronously force: state IDLE, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, aes_cs=0, aes_we=0, counters=0, key-cache valid=0.
REQ-031 req_ready SHALL rise to 1 in the first cycle after reset_n deasserts.
REQ-032 Reset asserted mid-job SHALL abandon the job with no response generated.

Configuration
REQ-033 Macro ADAM_AES_SEQ_KEY_CACHE_EN defined: the block SHALL store the key and keylen of the last job that completed WAIT_RDY without timeout.
REQ-034 Macro defined, next job with identical key and keylen: the block SHALL go WCFG -> WBLK, skipping WKEY, INIT and WAIT_RDY.
REQ-035 Macro defined, any timeout: the cache SHALL be invalidated.
REQ-036 Macro not defined: every job SHALL run the full sequence and no cache storage SHALL exist.

Verification
REQ-037 AES-128 encrypt: key 000102030405060708090a0b0c0d0e0f, block 00112233445566778899aabbccddeeff -> rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err=0, 4 KEY writes.
REQ-038 AES-256 encrypt: key 00..1f, same block -> rsp_data 8ea2b7ca516745bfeafc49904b496089, 8 KEY writes, CONFIG=0x3.
REQ-039 Decrypt (encdec=0) of the REQ-037 ciphertext with the REQ-037 key -> rsp_data 00112233445566778899aabbccddeeff.
REQ-040 Core model holding STATUS=0, TIMEOUT_CYCLES=8 -> DONE after 8 poll cycles, rsp_err=1, rsp_data=0; the next job completes normally.
REQ-041 rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable for all 5 cycles; req_ready=0 until the handshake.
REQ-042 With ADAM_AES_SEQ_KEY_CACHE_EN, two back-to-back jobs with the same key -> the second job shows no KEY or CTRL=0x1 writes and finishes 6+ cycles sooner; reset_n pulsed mid-WBLK -> IDLE, no rsp_valid.
